// File: rtl/spi_mem_slave.sv
// spi_mem_slave: SPI mode-0 slave bridging write (0x02) / read (0x03) bursts onto a byte-wide memory port.
module spi_mem_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       mem_wr,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din,
  input  logic [7:0] mem_dout,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WR_DATA, RD_DATA, IGNORE} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sclk_s, r_cs_s, r_mosi_s;
  logic       r_sclk_d, r_cs_d;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx, r_addr, r_din;
  logic       r_wr_cmd, r_inc, r_load, r_wr, r_done, r_err;
  logic       w_sclk, w_cs, w_mosi, w_rise, w_fall, w_cs_fall, w_act, w_byte_done, w_legal;
  logic [7:0] w_byte;
  assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
  assign w_cs        = r_cs_s[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_s[SYNC_STAGES-1];
  assign w_rise      = w_sclk & ~r_sclk_d;
  assign w_fall      = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = r_cs_d & ~w_cs;
  // a high cs_n masks any sclk edge seen in the same cycle
  assign w_act       = w_rise & ~w_cs & (r_state != IDLE);
  assign w_byte_done = w_act & (r_bit_cnt == 3'd7);
  assign w_byte      = {r_rx, w_mosi};
  assign w_legal     = (w_byte == 8'h02) || (w_byte == 8'h03);
  assign miso        = (r_state == RD_DATA) ? r_tx[7] : 1'b0;
  assign mem_wr      = r_wr;
  assign mem_addr    = r_addr;
  assign mem_din     = r_din;
  assign done        = r_done;
  assign err         = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sclk_s <= '0;
      r_cs_s   <= '1;
      r_mosi_s <= '0;
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], sclk};
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], cs_n};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], mosi};
      r_sclk_d <= w_sclk;
      r_cs_d   <= w_cs;
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = w_cs_fall ? CMD : IDLE;
    else if (w_cs)
      w_next = IDLE;
    else if (w_byte_done)
      w_next = (r_state == CMD)  ? (w_legal ? ADDR : IGNORE) :
               (r_state == ADDR) ? (r_wr_cmd ? WR_DATA : RD_DATA) : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_addr    <= '0;
      r_din     <= '0;
      r_wr_cmd  <= 1'b0;
      r_inc     <= 1'b0;
      r_load    <= 1'b0;
      r_wr      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_inc  <= 1'b0;
      r_load <= 1'b0;
      if (r_state == IDLE)
        r_bit_cnt <= '0;
      else if (w_act) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_rx      <= w_byte[6:0];
      end
      if (w_byte_done && r_state == CMD) begin
        r_wr_cmd <= (w_byte == 8'h02);
        r_err    <= ~w_legal;
      end
      if (w_byte_done && r_state == ADDR) begin
        r_addr <= w_byte;
        r_load <= 1'b1;
      end
      if (w_byte_done && r_state == WR_DATA) begin
        r_din <= w_byte;
        r_wr  <= 1'b1;
      end
      if (w_byte_done && (r_state == WR_DATA || r_state == RD_DATA)) begin
        r_done <= 1'b1;
        r_inc  <= 1'b1;
      end
      if (r_inc) begin
        r_addr <= r_addr + 8'd1;
        r_load <= 1'b1;
      end
      // the fall that closes a byte (counter back at 0) must not disturb the freshly loaded byte
      if (r_state == RD_DATA && r_load)
        r_tx <= mem_dout;
      else if (r_state == RD_DATA && w_fall && r_bit_cnt != 3'd0)
        r_tx <= {r_tx[6:0], 1'b0};
    end
  end
endmodule

// File: tb/tb_spi_mem_slave.sv
// tb_spi_mem_slave: SPI master model with write/read scoreboards against a behavioural byte store.
module tb_spi_mem_slave;
  logic clk = 1'b0, rst, sclk, cs_n, mosi, miso, mem_wr, done, err, mem_clr;
  logic [7:0] mem_addr, mem_din, mem_dout;
  logic [7:0] store [256];
  logic [15:0] wr_q [$];
  logic [7:0] rd_q [$];
  logic [7:0] tx_q [$];
  int n_tests = 0, n_fail = 0;
  int wr_cnt = 0, done_cnt = 0, err_cyc = 0, miso_hi = 0;
  logic miso_watch = 1'b0;
  typedef struct {
    logic [7:0] cmd, addr, data, rd;
    int n_wr, n_done;
  } vec_t;
  vec_t vec [6];
  spi_mem_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .done(done), .err(err)
  );
  always #5 clk = ~clk;
  assign mem_dout = store[mem_addr];
  always @(posedge clk) begin
    if (mem_clr) foreach (store[i]) store[i] <= 8'h00;
    else if (mem_wr) store[mem_addr] <= mem_din;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mem_wr) begin
      wr_cnt++;
      chk("mem_wr_addr_data", {16'h0, mem_addr, mem_din}, wr_q.size() != 0 ? {16'h0, wr_q.pop_front()} : 32'hxxxx_xxxx);
    end
    if (done) done_cnt++;
    if (err) err_cyc++;
    if (miso_watch && miso) miso_hi++;
  end
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      #60;
      rx[i] = miso;
      sclk = 1'b1;
      #60;
      sclk = 1'b0;
    end
  endtask
  task automatic xfer(input int last_bits);
    logic [7:0] rx;
    cs_n = 1'b0;
    #60;
    for (int i = 0; i < tx_q.size(); i++) begin
      spi_byte(tx_q[i], (i == tx_q.size() - 1) ? last_bits : 8, rx);
      if (tx_q[0] == 8'h03 && i >= 2)
        chk("miso_rd_byte", rx, rd_q.size() != 0 ? rd_q.pop_front() : 8'hxx);
    end
    #60;
    cs_n = 1'b1;
    #200;
  endtask
  initial begin
    int w0, d0, e0;
    logic [7:0] rx;
    vec[0] = '{8'h02, 8'h10, 8'hA5, 8'h00, 1, 1};
    vec[1] = '{8'h03, 8'h10, 8'h00, 8'hA5, 0, 1};
    vec[2] = '{8'h02, 8'h40, 8'h3C, 8'h00, 1, 1};
    vec[3] = '{8'h03, 8'h40, 8'h00, 8'h3C, 0, 1};
    vec[4] = '{8'h02, 8'h00, 8'h81, 8'h00, 1, 1};
    vec[5] = '{8'h03, 8'h00, 8'h00, 8'h81, 0, 1};
    rst = 1'b1; mem_clr = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {miso, mem_wr, done, err, mem_addr, mem_din}, 20'h0);
    rst = 1'b0; mem_clr = 1'b0;
    repeat (4) @(negedge clk);
    for (int v = 0; v < 6; v++) begin
      w0 = wr_cnt; d0 = done_cnt; e0 = err_cyc;
      tx_q = '{vec[v].cmd, vec[v].addr, vec[v].data};
      if (vec[v].cmd == 8'h02) wr_q.push_back({vec[v].addr, vec[v].data});
      else rd_q.push_back(vec[v].rd);
      xfer(8);
      chk("vec_mem_wr_count", wr_cnt - w0, vec[v].n_wr);
      chk("vec_done_count", done_cnt - d0, vec[v].n_done);
      chk("vec_err_count", err_cyc - e0, 0);
      if (vec[v].cmd == 8'h02) chk("vec_store", store[vec[v].addr], vec[v].data);
    end
    w0 = wr_cnt; d0 = done_cnt;
    tx_q = '{8'h02, 8'hFE, 8'h11, 8'h22, 8'h33};
    wr_q.push_back(16'hFE11); wr_q.push_back(16'hFF22); wr_q.push_back(16'h0033);
    xfer(8);
    chk("burst_wr_count", wr_cnt - w0, 3);
    chk("burst_done_count", done_cnt - d0, 3);
    chk("burst_store_00", store[8'h00], 8'h33);
    d0 = done_cnt;
    tx_q = '{8'h03, 8'hFE, 8'h00, 8'h00, 8'h00};
    rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33);
    xfer(8);
    chk("burst_rd_done_count", done_cnt - d0, 3);
    w0 = wr_cnt; e0 = err_cyc; miso_hi = 0; miso_watch = 1'b1;
    tx_q = '{8'h7F, 8'h03, 8'h10};
    xfer(8);
    miso_watch = 1'b0;
    chk("illegal_err_cycles", err_cyc - e0, 1);
    chk("illegal_mem_wr", wr_cnt - w0, 0);
    chk("illegal_miso_high", miso_hi, 0);
    tx_q = '{8'h02, 8'h20, 8'h5A};
    wr_q.push_back(16'h205A);
    xfer(8);
    w0 = wr_cnt; d0 = done_cnt;
    tx_q = '{8'h02, 8'h20, 8'hC3};
    xfer(5);
    chk("abort_mem_wr", wr_cnt - w0, 0);
    chk("abort_done", done_cnt - d0, 0);
    tx_q = '{8'h03, 8'h20, 8'h00};
    rd_q.push_back(8'h5A);
    xfer(8);
    w0 = wr_cnt;
    cs_n = 1'b0;
    #60;
    spi_byte(8'h02, 8, rx);
    spi_byte(8'h30, 8, rx);
    spi_byte(8'hC3, 4, rx);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("midreset_outputs", {miso, mem_wr, done, err, mem_addr, mem_din}, 20'h0);
    #60;
    cs_n = 1'b1;
    #200;
    chk("midreset_mem_wr", wr_cnt - w0, 0);
    tx_q = '{8'h02, 8'h30, 8'h77};
    wr_q.push_back(16'h3077);
    xfer(8);
    tx_q = '{8'h03, 8'h30, 8'h00};
    rd_q.push_back(8'h77);
    xfer(8);
    chk("post_reset_store", store[8'h30], 8'h77);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_mem_slave.md
SPI_MEM_SLAVE -- requirements
Module: spi_mem_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sclk, cs_n and mosi (legal 2..3).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port sclk  input  1  SPI serial clock, mode 0, asynchronous to clk.
REQ-005 SHALL have port cs_n  input  1  SPI chip select, active-low.
REQ-006 SHALL have port mosi  input  1  serial data in, MSB first.
REQ-007 SHALL have port miso  output  1  serial data out, MSB first.
REQ-008 SHALL have port mem_wr  output  1  single-cycle write strobe to the spi_mem store.
REQ-009 SHALL have port mem_addr  output  8  registered memory address.
REQ-010 SHALL have port mem_din  output  8  registered write data.
REQ-011 SHALL have port mem_dout  input  8  asynchronous read data from store, valid same cycle as mem_addr.
REQ-012 SHALL have port done  output  1  one-cycle pulse per completed data byte.
REQ-013 SHALL have port err  output  1  one-cycle pulse on illegal command byte.

Function
REQ-014 SHALL pass sclk, cs_n, mosi through SYNC_STAGES flops; edge detection on synchronized sclk; sclk high and low phases each >= 4 clk periods.
REQ-015 SHALL sample mosi on each detected sclk rise while synchronized cs_n low; 3-bit bit counter, byte complete on 8th rise, counter wraps to 0.
REQ-016 SHALL implement FSM IDLE, CMD, ADDR, WR_DATA, RD_DATA, IGNORE.
REQ-017 IDLE -> CMD on synchronized cs_n falling; bit counter cleared.
REQ-018 CMD byte 0x02 -> ADDR (write); 0x03 -> ADDR (read); any other -> IGNORE with err pulse next cycle.
REQ-019 ADDR byte complete: mem_addr <= byte next cycle; -> WR_DATA or RD_DATA per command.
REQ-020 WR_DATA byte complete: next cycle mem_din <= byte, mem_wr = 1 for exactly one cycle, done = 1; following cycle mem_addr increments.
REQ-021 RD_DATA: one cycle after mem_addr is updated, tx shift register loads mem_dout, miso = bit 7 before the first data sclk rise.
REQ-022 RD_DATA: on each sclk fall with bit counter != 0, tx register shifts left, miso = next bit; fall with bit counter == 0 does not shift.
REQ-023 RD_DATA byte complete: done = 1 next cycle; mem_addr increments; tx register reloads from mem_dout one cycle after increment.
REQ-024 Burst: transfer continues byte after byte until cs_n rises; mem_addr wraps 0xFF -> 0x00.
REQ-025 IGNORE: no mem_wr, miso = 0, remains until cs_n rises.
REQ-026 Synchronized cs_n rising from any state -> IDLE next cycle; partial byte discarded, no mem_wr, no done.
REQ-027 cs_n rise and sclk edge detected same cycle: cs_n wins, edge ignored.
REQ-028 miso = 0 whenever not in RD_DATA; mem_wr never asserted outside WR_DATA.
REQ-029 mem_addr, mem_din hold value between transfers; no store access when no transaction active.

Reset
REQ-030 rst high at a clk rise SHALL force IDLE, bit counter 0, synchronizers to idle levels (sclk 0, cs_n 1, mosi 0), miso 0, mem_wr 0, mem_addr 0x00, mem_din 0x00, done 0, err 0.
REQ-031 rst mid-transaction SHALL abort without mem_wr; after release, a new transaction begins only after a cs_n falling edge following release.

Verification
REQ-032 Write: cs_n low, bytes 0x02,0x10,0xA5, cs_n high -> one mem_wr pulse, mem_addr 0x10, mem_din 0xA5, one done; spi_mem[0x10] = 0xA5.
REQ-033 Read: store[0x10]=0xA5; bytes 0x03,0x10,0x00 -> miso shifts 1,0,1,0,0,1,0,1 during byte 3; no mem_wr; one done.
REQ-034 Burst wrap: 0x02,0xFE,0x11,0x22,0x33 -> writes 0xFE=0x11, 0xFF=0x22, 0x00=0x33; three mem_wr, three done.
REQ-035 Illegal command 0x7F then 16 clocks -> one err pulse, no mem_wr, miso 0 throughout.
REQ-036 Abort: 0x02,0x20 then 5 bits of data, cs_n high -> no mem_wr; next 0x03,0x20 read returns prior contents.
REQ-037 rst asserted during byte 3 of a write -> all outputs at reset values next cycle, no mem_wr; subsequent full write succeeds.
